// File: rtl/demux_1xn_stream.sv
// ============================================================================
// Module   : demux_1xn_stream
// Purpose  : 1-to-N valid/ready stream demultiplexer, addressed or scan mode,
//            one-entry register per output channel.
//            Optional macro DEMUX_OOR_ERR_EN adds err pulse and err_cnt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_1xn_stream #(
  parameter  int DW = 8,
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              a_valid,
  input  logic [DW-1:0]     a,
  input  logic [SW-1:0]     s,
  output logic              a_ready,
  output logic [N*DW-1:0]   y,
  output logic [N-1:0]      y_valid,
  input  logic [N-1:0]      y_ready,
  output logic [SW-1:0]     ptr,
`ifdef DEMUX_OOR_ERR_EN
  output logic [7:0]        err_cnt,
`endif
  output logic              err
);

  localparam logic [SW:0]   C_N    = (SW+1)'(N);
  localparam logic [SW-1:0] C_LAST = SW'(N - 1);

  logic [SW-1:0] w_tgt;
  logic          w_in_range;
  logic          w_sel_free;
  logic          w_accept;
  logic [N-1:0]  w_free;
  logic [N-1:0]  w_fill;
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] ptr_d;

  always_comb begin
    w_tgt      = mode ? ptr_q : s;
    w_in_range = ({1'b0, w_tgt} < C_N);
    w_free     = ~y_valid | y_ready;
    w_sel_free = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (w_tgt == SW'(k)) w_sel_free = w_free[k];
    end
    // Out-of-range targets are always accepted so the beat can be discarded.
    a_ready  = w_in_range ? w_sel_free : 1'b1;
    w_accept = a_valid & a_ready;
    w_fill   = '0;
    for (int k = 0; k < N; k++) begin
      w_fill[k] = w_accept & w_in_range & (w_tgt == SW'(k));
    end
    ptr_d = ptr_q;
    if (w_accept && mode) begin
      ptr_d = (ptr_q == C_LAST) ? '0 : ptr_q + SW'(1);
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_ch
    logic [DW-1:0] data_q;
    logic          valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (w_fill[k]) begin
        data_q  <= a;
        valid_q <= 1'b1;
      end else if (y_ready[k]) begin
        valid_q <= 1'b0;
      end
    end

    assign y[k*DW +: DW] = data_q;
    assign y_valid[k]    = valid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

`ifdef DEMUX_OOR_ERR_EN
  logic       err_q;
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= w_accept & ~w_in_range;
      if (w_accept && !w_in_range && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire
